// File: rtl/gate_sweep_ctrl.sv
// Exhaustive sweep sequencer for an N-input gate: drives every vector, compares y_in to a truth table.
// Optional build macro GATE_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module gate_sweep_ctrl #(
   parameter int N      = 2,
   parameter int SETTLE = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [(1<<N)-1:0] truth,
   input  logic              y_in,
   output logic [N-1:0]      stim,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [N:0]        err_count,
   output logic [N-1:0]      first_fail
);

   typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SETTLE, S_CHECK, S_DONE} state_t;

   localparam logic [7:0] CNT_LD = (SETTLE > 0) ? 8'(SETTLE - 1) : 8'd0;

   state_t         state_q, state_d;
   logic [N-1:0]   idx_q, idx_d;
   logic [N-1:0]   stim_q, stim_d;
   logic [N-1:0]   ff_q, ff_d;
   logic [N:0]     err_q, err_d;
   logic           pass_q, pass_d;
   logic [7:0]     cnt_q, cnt_d;
   logic           mismatch;
   logic           last_vec;

   assign mismatch = (y_in != truth[idx_q]);
   assign last_vec = &idx_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (start) state_d = S_DRIVE;
         S_DRIVE:  state_d = (SETTLE > 0) ? S_SETTLE : S_CHECK;
         S_SETTLE: if (cnt_q == 8'd0) state_d = S_CHECK;
         S_CHECK: begin
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
            if (last_vec || mismatch) state_d = S_DONE;
            else                      state_d = S_DRIVE;
`else
            if (last_vec) state_d = S_DONE;
            else          state_d = S_DRIVE;
`endif
         end
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath: stim only moves on entry to DRIVE; pass is resolved on the way into DONE
   // so it is already valid during the done pulse.
   always_comb begin
      idx_d  = idx_q;
      stim_d = stim_q;
      ff_d   = ff_q;
      err_d  = err_q;
      pass_d = pass_q;
      cnt_d  = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               idx_d  = '0;
               stim_d = '0;
               ff_d   = '0;
               err_d  = '0;
               pass_d = 1'b0;
            end
         end
         S_DRIVE:  cnt_d = CNT_LD;
         S_SETTLE: if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
         S_CHECK: begin
            if (mismatch) begin
               err_d = err_q + 1'b1;
               if (err_q == '0) ff_d = idx_q;
            end
            if (state_d == S_DRIVE) begin
               idx_d  = idx_q + 1'b1;
               stim_d = idx_q + 1'b1;
            end
            if (state_d == S_DONE) pass_d = (err_d == '0);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= '0;
         stim_q <= '0;
         ff_q   <= '0;
         err_q  <= '0;
         pass_q <= 1'b0;
         cnt_q  <= 8'd0;
      end else begin
         idx_q  <= idx_d;
         stim_q <= stim_d;
         ff_q   <= ff_d;
         err_q  <= err_d;
         pass_q <= pass_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      busy = (state_q != S_IDLE);
      done = (state_q == S_DONE);
   end

   assign stim       = stim_q;
   assign pass       = pass_q;
   assign err_count  = err_q;
   assign first_fail = ff_q;

endmodule
